pc_seq: RTL and testbench
=========================

# pc_seq

Parametrised program-counter sequencer for the MIPS core, the successor to the fixed-width 32-bit `pc`. It generates the fetch address every cycle and handles reset hold-off, pipeline stall, `beq`/`bne` branches, absolute jumps, jump-register, and link/return. It includes a small return-address stack (RAS) for `jal`/`jr $ra` pairs. It sits between the control unit / ALU flags and instruction memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of all address/offset buses
- `RESET_ADDR`, 0, PC value on reset and during hold-off
- `INSTR_BYTES`, 4, sequential increment (power of two)
- `RESET_HOLD`, 2, cycles `resetControl` stays high after `Reset` deasserts (≥1)
- `RAS_DEPTH`, 4, return-address stack entries (≥2)

Ports:
- `Clk` in 1: single clock, all state on rising edge
- `Reset` in 1: synchronous, active-high
- `stall` in 1: hold PC and RAS this cycle
- `zeroFlag` in 1: ALU zero result
- `branchFlag` in 1: current instruction is a conditional branch
- `branchNe` in 1: branch mode, 0 = `beq` (taken on zero), 1 = `bne` (taken on non-zero)
- `branchOffset` in ADDR_WIDTH: signed byte offset, already sign-extended and shifted
- `jmpFlag` in 1: absolute jump
- `jmpAddress` in ADDR_WIDTH: absolute byte target
- `jrFlag` in 1: jump-register
- `jrAddress` in ADDR_WIDTH: register-file target
- `retFlag` in 1: `jr $ra`; use the RAS top when available
- `linkFlag` in 1: push `linkAddr` onto the RAS (`jal`/`jalr`)
- `addr` out ADDR_WIDTH: current fetch address (registered)
- `linkAddr` out ADDR_WIDTH: `addr + INSTR_BYTES` (combinational)
- `resetControl` out 1: registered; high during reset hold-off
- `rasEmpty` out 1: RAS count == 0
- `rasOverflow` out 1: sticky, set when a push drops the oldest entry
- `rasUnderflow` out 1: sticky, set when `retFlag` is seen with an empty RAS

## Operation
States:
- HOLD: entered on `Reset`. Counter `holdCnt` is cleared. Each edge it increments, and it moves to RUN at the edge where `holdCnt == RESET_HOLD-1`.
- RUN: the PC advances each non-stalled edge.

Reset values:
- `addr = RESET_ADDR`, `resetControl = 1`, RAS count 0, `rasOverflow = 0`, `rasUnderflow = 0`.

Next PC in RUN with `stall = 0`, first match wins:
- `retFlag`: RAS top if non-empty (pop); otherwise `jrAddress`, and set `rasUnderflow`
- `jrFlag`: `jrAddress`
- `jmpFlag`: `jmpAddress`
- taken = `branchFlag & (zeroFlag ^ branchNe)`: `addr + INSTR_BYTES + branchOffset`
- otherwise `addr + INSTR_BYTES`

Arithmetic and alignment:
- All arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Target low `log2(INSTR_BYTES)` bits are forced to 0.

RAS behaviour:
- Circular buffer of `RAS_DEPTH` entries.
- Push when `linkFlag`, in RUN, `stall = 0`, value `linkAddr`.
- Push when full: overwrite the oldest entry, count stays `RAS_DEPTH`, set `rasOverflow`.
- `retFlag` and `linkFlag` in the same cycle: pop first, then push, so the top is replaced and count is unchanged.
- `rasOverflow` and `rasUnderflow` clear only on `Reset`.

Hold and stall:
- In HOLD or with `stall = 1`, `addr` and the RAS are unchanged; all control inputs are ignored.

## Timing
- `addr` updates one edge after the controlling inputs are sampled; redirect latency is 1 cycle.
- `resetControl` stays high on the `Reset` edge plus exactly `RESET_HOLD` further edges. The first `addr` change happens on the edge after `resetControl` falls.
- `Reset` mid-operation (any state, including during stall): at the next edge, `addr = RESET_ADDR`, RAS is flushed, stickies are cleared, state is HOLD.
- `linkAddr` is combinational from `addr`; no extra latency.
- `rasEmpty` reflects the registered count.

## Test plan
- Reset, `RESET_HOLD = 2`: `Reset` high 1 cycle, then low. Required: `resetControl` high for 3 sampled edges, `addr` = 0 throughout, then `addr` sequence 4, 8, 0xC.
- Jump priority: `jmpFlag = 1` and `branchFlag = 1`, `zeroFlag = 1`, `jmpAddress = 0xFFF`. Required: `addr = 0xFFC` next cycle (aligned); branch ignored.
- Branch modes at `addr = 0x100`, `branchOffset = 0xFFFFFFF8`:
  - `beq` with `zeroFlag = 1` → `0xFC`
  - `bne` with `zeroFlag = 1` → `0x104`
  - `bne` with `zeroFlag = 0` → `0xFC`
- RAS: 5 `jal` (`linkFlag` + `jmpFlag`), `RAS_DEPTH = 4`. Required: `rasOverflow = 1`. The next 4 `retFlag` return to the last 4 link addresses, newest first. A 5th `retFlag` uses `jrAddress` and sets `rasUnderflow`.
- Stall: assert `stall` for 3 cycles while `jmpFlag = 1`. Required: `addr` frozen and no RAS change; the jump takes effect on the first unstalled edge.
- Wrap: `addr = 0xFFFFFFFC`, sequential. Required: `addr = 0`. Then assert `Reset` while stalled mid-RAS-use. Required: `addr = RESET_ADDR`, `rasEmpty = 1`, both sticky flags 0.

Source files
------------

// File: rtl/pc_seq_if.sv
// Bus bundle between the control unit / ALU flags (master) and the PC sequencer (slave).
interface pc_seq_if #(
  parameter int ADDR_WIDTH = 32
);
  // Control inputs to the sequencer
  logic                  stall;
  logic                  zeroFlag;
  logic                  branchFlag;
  logic                  branchNe;
  logic [ADDR_WIDTH-1:0] branchOffset;
  logic                  jmpFlag;
  logic [ADDR_WIDTH-1:0] jmpAddress;
  logic                  jrFlag;
  logic [ADDR_WIDTH-1:0] jrAddress;
  logic                  retFlag;
  logic                  linkFlag;

  // Sequencer outputs
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] linkAddr;
  logic                  resetControl;
  logic                  rasEmpty;
  logic                  rasOverflow;
  logic                  rasUnderflow;

  modport master (
    output stall, zeroFlag, branchFlag, branchNe, branchOffset,
           jmpFlag, jmpAddress, jrFlag, jrAddress, retFlag, linkFlag,
    input  addr, linkAddr, resetControl, rasEmpty, rasOverflow, rasUnderflow
  );

  modport slave (
    input  stall, zeroFlag, branchFlag, branchNe, branchOffset,
           jmpFlag, jmpAddress, jrFlag, jrAddress, retFlag, linkFlag,
    output addr, linkAddr, resetControl, rasEmpty, rasOverflow, rasUnderflow
  );
endinterface

// File: rtl/pc_seq.sv
// Program-counter sequencer: reset hold-off, stall, branches, jumps,
// jump-register and a circular return-address stack for jal / jr $ra pairs.
module pc_seq #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter int                    INSTR_BYTES = 4,
  parameter int                    RESET_HOLD  = 2,
  parameter int                    RAS_DEPTH   = 4
) (
  input logic     Clk,
  input logic     Reset,
  pc_seq_if.slave bus
);

  localparam int PTR_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));
  localparam logic [PTR_W-1:0]      LAST_IDX   = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      CNT_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE   = HOLD_W'(1);

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Sequencer state
  logic [0:0]            state_reg;
  logic [HOLD_W-1:0]     hold_cnt_reg;
  logic                  rc_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Return-address stack: wr_ptr is the next free slot, top is one below it
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      wr_ptr_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_next;
  logic                  ovf_reg;
  logic                  unf_reg;

  // Decode helpers
  logic                  run_en;
  logic                  ras_empty;
  logic [PTR_W-1:0]      top_ptr;
  logic [ADDR_WIDTH-1:0] top_val;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic                  taken;
  logic [ADDR_WIDTH-1:0] target;
  logic                  pop;
  logic                  push;
  logic                  push_we;
  logic                  underflow_evt;
  logic                  overflow_evt;
  logic [PTR_W-1:0]      ptr_pop;
  logic [CNT_W-1:0]      cnt_pop;

  // The PC only moves once resetControl has been seen low, so the first
  // fetch-address change lands on the edge after resetControl falls.
  assign run_en    = (state_reg == ST_RUN) && !rc_reg && !bus.stall;
  assign ras_empty = (cnt_reg == '0);
  assign top_ptr   = (wr_ptr_reg == '0) ? LAST_IDX : (wr_ptr_reg - PTR_ONE);
  assign top_val   = ras_mem[top_ptr];
  assign link_addr = addr_reg + STEP;
  assign taken     = bus.branchFlag & (bus.zeroFlag ^ bus.branchNe);

  assign pop           = run_en && bus.retFlag && !ras_empty;
  assign underflow_evt = run_en && bus.retFlag && ras_empty;
  assign push          = run_en && bus.linkFlag;
  assign push_we       = push && !Reset;

  // Select the redirect target; first matching source wins
  always_comb begin
    target = link_addr;
    if (bus.retFlag) begin
      target = ras_empty ? bus.jrAddress : top_val;
    end else if (bus.jrFlag) begin
      target = bus.jrAddress;
    end else if (bus.jmpFlag) begin
      target = bus.jmpAddress;
    end else if (taken) begin
      target = link_addr + bus.branchOffset;
    end
  end

  // Next fetch address: aligned target when running, otherwise hold
  always_comb begin
    addr_next = addr_reg;
    if (run_en) begin
      addr_next = target & ALIGN_MASK;
    end
  end

  // Stack bookkeeping: pop first, then push, so ret+link replaces the top
  always_comb begin
    ptr_pop      = wr_ptr_reg;
    cnt_pop      = cnt_reg;
    overflow_evt = 1'b0;
    if (pop) begin
      ptr_pop = top_ptr;
      cnt_pop = cnt_reg - CNT_ONE;
    end
    wr_ptr_next = ptr_pop;
    cnt_next    = cnt_pop;
    if (push) begin
      wr_ptr_next = (ptr_pop == LAST_IDX) ? '0 : (ptr_pop + PTR_ONE);
      if (cnt_pop == CNT_FULL) begin
        // Full: the free slot coincides with the oldest entry, which is dropped
        overflow_evt = 1'b1;
      end else begin
        cnt_next = cnt_pop + CNT_ONE;
      end
    end
  end

  // Stack storage write; contents need no reset because the count is flushed
  always_ff @(posedge Clk) begin
    if (push_we) begin
      ras_mem[ptr_pop] <= link_addr;
    end
  end

  // Hold-off FSM, fetch address, stack pointers and sticky flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg    <= ST_HOLD;
      hold_cnt_reg <= '0;
      rc_reg       <= 1'b1;
      addr_reg     <= RESET_ADDR;
      wr_ptr_reg   <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      rc_reg <= (state_reg == ST_HOLD);
      if (state_reg == ST_HOLD) begin
        if (hold_cnt_reg == HOLD_LAST) begin
          state_reg    <= ST_RUN;
          hold_cnt_reg <= '0;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_ONE;
        end
      end
      addr_reg   <= addr_next;
      wr_ptr_reg <= wr_ptr_next;
      cnt_reg    <= cnt_next;
      ovf_reg    <= ovf_reg | overflow_evt;
      unf_reg    <= unf_reg | underflow_evt;
    end
  end

  assign bus.addr         = addr_reg;
  assign bus.linkAddr     = link_addr;
  assign bus.resetControl = rc_reg;
  assign bus.rasEmpty     = ras_empty;
  assign bus.rasOverflow  = ovf_reg;
  assign bus.rasUnderflow = unf_reg;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: directed scenarios followed by random traffic,
// each edge predicted by a queue-based behavioural model.
module tb_pc_seq;

  localparam int          AW = 32;
  localparam logic [31:0] RA = 32'h0;
  localparam int          IB = 4;
  localparam int          RH = 2;
  localparam int          RD = 4;

  typedef struct {
    logic        rst, stall, zero, br, bne;
    logic [31:0] off;
    logic        jmp;
    logic [31:0] ja;
    logic        jr;
    logic [31:0] jra;
    logic        ret, link;
  } stim_t;

  typedef struct {
    logic [31:0] addr, link;
    logic        rc, empty, ovf, unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn = 0;
  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_addr;
  logic [31:0] m_stack[$];
  logic        m_ovf, m_unf;
  int          m_since;

  pc_seq_if #(.ADDR_WIDTH(AW)) bus ();

  pc_seq #(
    .ADDR_WIDTH(AW), .RESET_ADDR(RA), .INSTR_BYTES(IB),
    .RESET_HOLD(RH), .RAS_DEPTH(RD)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, stall: 1'b0, zero: 1'b0, br: 1'b0, bne: 1'b0, off: 32'h0,
          jmp: 1'b0, ja: 32'h0, jr: 1'b0, jra: 32'h0, ret: 1'b0, link: 1'b0};
    return s;
  endfunction

  // Behavioural model of one rising edge
  task automatic model_edge(input stim_t s);
    logic [31:0] lnk, tgt;
    if (s.rst) begin
      m_addr  = RA;
      m_stack = {};
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_since = 0;
    end else begin
      // resetControl is high for the reset edge plus RH more edges; the PC
      // may move only on an edge where it was already low beforehand.
      if (m_since > RH && !s.stall) begin
        lnk = m_addr + IB;
        if (s.ret) begin
          if (m_stack.size() > 0) tgt = m_stack.pop_back();
          else begin
            tgt   = s.jra;
            m_unf = 1'b1;
          end
        end else if (s.jr) tgt = s.jra;
        else if (s.jmp) tgt = s.ja;
        else if (s.br && (s.zero != s.bne)) tgt = lnk + s.off;
        else tgt = lnk;
        if (s.link) begin
          m_stack.push_back(lnk);
          if (m_stack.size() > RD) begin
            void'(m_stack.pop_front());
            m_ovf = 1'b1;
          end
        end
        m_addr = tgt & ~(IB - 1);
      end
      if (m_since < 1000) m_since++;
    end
  endtask

  // Drive one cycle of stimulus and queue the predicted post-edge outputs
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst              = s.rst;
    bus.stall        = s.stall;
    bus.zeroFlag     = s.zero;
    bus.branchFlag   = s.br;
    bus.branchNe     = s.bne;
    bus.branchOffset = s.off;
    bus.jmpFlag      = s.jmp;
    bus.jmpAddress   = s.ja;
    bus.jrFlag       = s.jr;
    bus.jrAddress    = s.jra;
    bus.retFlag      = s.ret;
    bus.linkFlag     = s.link;
    model_edge(s);
    e.addr  = m_addr;
    e.link  = m_addr + IB;
    e.rc    = (m_since <= RH);
    e.empty = (m_stack.size() == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  // Wait until the outputs of the step just issued are stable
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one prediction per edge and compares every output
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d addr=%h rc=%b empty=%b ovf=%b unf=%b",
                 n_txn, bus.addr, bus.resetControl, bus.rasEmpty, bus.rasOverflow, bus.rasUnderflow);
        chk("mon_addr", bus.addr, e.addr);
        chk("mon_link", bus.linkAddr, e.link);
        chk("mon_rc", 32'(bus.resetControl), 32'(e.rc));
        chk("mon_empty", 32'(bus.rasEmpty), 32'(e.empty));
        chk("mon_ovf", 32'(bus.rasOverflow), 32'(e.ovf));
        chk("mon_unf", 32'(bus.rasUnderflow), 32'(e.unf));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    stim_t s;
    logic [31:0] boot_addr [6];
    logic        boot_rc   [6];
    logic [31:0] ret_exp   [4];
    boot_addr = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    boot_rc   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ret_exp   = '{32'h1034, 32'h1024, 32'h1014, 32'h1004};

    bus.stall = 1'b0; bus.zeroFlag = 1'b0; bus.branchFlag = 1'b0; bus.branchNe = 1'b0;
    bus.branchOffset = '0; bus.jmpFlag = 1'b0; bus.jmpAddress = '0; bus.jrFlag = 1'b0;
    bus.jrAddress = '0; bus.retFlag = 1'b0; bus.linkFlag = 1'b0;
    repeat (2) @(posedge clk);

    // Reset for one cycle, then hold-off and the first sequential fetches
    s = idle(); s.rst = 1'b1; step(s); settle();
    chk("reset_addr", bus.addr, RA);
    chk("reset_rc", 32'(bus.resetControl), 32'h1);
    chk("reset_empty", 32'(bus.rasEmpty), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step(idle()); settle();
      chk("boot_addr", bus.addr, boot_addr[i]);
      chk("boot_rc", 32'(bus.resetControl), 32'(boot_rc[i]));
    end

    // Jump beats a taken branch and is aligned
    s = idle(); s.jmp = 1'b1; s.ja = 32'hFFF; s.br = 1'b1; s.zero = 1'b1; s.off = 32'h40;
    step(s); settle();
    chk("jmp_priority", bus.addr, 32'hFFC);

    // Branch modes from 0x100 with offset -8
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.jmp = 1'b1; s.ja = 32'h100; step(s);
      s = idle(); s.br = 1'b1; s.off = 32'hFFFF_FFF8;
      s.bne  = (i != 0);
      s.zero = (i != 2);
      step(s); settle();
      chk("branch_mode", bus.addr, (i == 1) ? 32'h104 : 32'hFC);
    end

    // Five jal calls into a four-entry stack
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.link = 1'b1; s.jmp = 1'b1; s.ja = 32'h1000 + 32'(i) * 32'h10;
      step(s);
    end
    settle();
    chk("ras_overflow", 32'(bus.rasOverflow), 32'h1);
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.ret = 1'b1; s.jra = 32'h7770; step(s); settle();
      chk("ras_return", bus.addr, ret_exp[i]);
    end
    s = idle(); s.ret = 1'b1; s.jra = 32'h2222; step(s); settle();
    chk("ras_underflow_addr", bus.addr, 32'h2220);
    chk("ras_underflow_flag", 32'(bus.rasUnderflow), 32'h1);
    chk("ras_empty_after", 32'(bus.rasEmpty), 32'h1);

    // Stall freezes a pending jump and ignores link requests
    s = idle(); s.link = 1'b1; s.jmp = 1'b1; s.ja = 32'h3000; step(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.stall = 1'b1; s.jmp = 1'b1; s.ja = 32'h4000; s.link = 1'b1; step(s); settle();
      chk("stall_hold", bus.addr, 32'h3000);
    end
    s = idle(); s.jmp = 1'b1; s.ja = 32'h4000; step(s); settle();
    chk("stall_release", bus.addr, 32'h4000);
    s = idle(); s.ret = 1'b1; s.jra = 32'h9990; step(s); settle();
    chk("stall_ras_intact", bus.addr, 32'h2224);

    // Wrap-around, then reset while stalled with the stack in use
    s = idle(); s.jmp = 1'b1; s.ja = 32'hFFFF_FFFC; step(s);
    step(idle()); settle();
    chk("wrap", bus.addr, 32'h0);
    s = idle(); s.link = 1'b1; s.jmp = 1'b1; s.ja = 32'h500; step(s);
    s = idle(); s.rst = 1'b1; s.stall = 1'b1; s.ret = 1'b1; step(s); settle();
    chk("midreset_addr", bus.addr, RA);
    chk("midreset_empty", 32'(bus.rasEmpty), 32'h1);
    chk("midreset_ovf", 32'(bus.rasOverflow), 32'h0);
    chk("midreset_unf", 32'(bus.rasUnderflow), 32'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      s       = idle();
      s.rst   = ($urandom_range(0, 79) == 0);
      s.stall = ($urandom_range(0, 5) == 0);
      s.zero  = 1'($urandom_range(0, 1));
      s.br    = ($urandom_range(0, 3) == 0);
      s.bne   = 1'($urandom_range(0, 1));
      s.off   = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
      s.jmp   = ($urandom_range(0, 7) == 0);
      s.ja    = $urandom;
      s.jr    = ($urandom_range(0, 9) == 0);
      s.jra   = $urandom;
      s.ret   = ($urandom_range(0, 5) == 0);
      s.link  = ($urandom_range(0, 4) == 0);
      step(s);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
